// File: rtl/sample_burst_framer_if.sv
// Handshake and output bundle between a sample source, the burst framer and
// the downstream averager. master drives samples/flush, slave is the framer.
interface sample_burst_framer_if #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [WIDTH-1:0] data_out;
  logic             dvalid;
  logic             burst_last;
  logic [LW-1:0]    fifo_level;

  modport master (
    output in_data, in_valid, flush,
    input  in_ready, data_out, dvalid, burst_last, fifo_level
  );

  modport slave (
    input  in_data, in_valid, flush,
    output in_ready, data_out, dvalid, burst_last, fifo_level
  );
endinterface

// File: rtl/sample_burst_framer.sv
// Sample burst framer: buffers sparse, back-pressured samples in a FIFO and
// replays them as hole-free dvalid bursts of BURST_LEN (or a shorter flushed
// burst), separated by a fixed dvalid-low gap so the averager can divide.
module sample_burst_framer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int GAP_CYCLES = 3
) (
  input logic                  clk,
  input logic                  rst,
  sample_burst_framer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {FILL, SEND, GAP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic [LW-1:0]    burst_cnt, burst_cnt_nxt;
  logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
  logic             push, pop;
  logic [WIDTH-1:0] data_q;
  logic             dvalid_q, last_q;

  // Ready comes only from the registered level, so a same-cycle pop never
  // opens a slot while full.
  assign bus.in_ready   = (level != LW'(FIFO_DEPTH));
  assign push           = bus.in_valid && bus.in_ready;
  // SEND pops every cycle; burst_cnt never exceeds the level at entry.
  assign pop            = (state == SEND);
  assign bus.fifo_level = level;
  assign bus.data_out   = data_q;
  assign bus.dvalid     = dvalid_q;
  assign bus.burst_last = last_q;

  // FIFO storage; contents are invalidated by the pointer reset alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Pointers wrap naturally (power-of-two depth); occupancy is tracked
  // separately in level rather than by pointer compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
    end
  end

  // Next-state logic. GAP is entered while the last word still sits in the
  // output register, so it lasts GAP_CYCLES+1 cycles to give GAP_CYCLES
  // dvalid-low cycles of its own; FILL and the output stage add one each.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    gap_cnt_nxt   = gap_cnt;
    case (state)
      FILL: begin
        if (level >= LW'(BURST_LEN)) begin
          state_nxt     = SEND;
          burst_cnt_nxt = LW'(BURST_LEN);
        end else if (bus.flush && (level != '0)) begin
          state_nxt     = SEND;
          burst_cnt_nxt = level;
        end
      end
      SEND: begin
        burst_cnt_nxt = burst_cnt - 1'b1;
        if (burst_cnt == LW'(1)) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GW'(GAP_CYCLES);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt   = FILL;
        else               gap_cnt_nxt = gap_cnt - 1'b1;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Registered output stage: popped word shows up the next cycle, data
  // holds while idle, and reset drops dvalid immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      dvalid_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      dvalid_q <= pop;
      last_q   <= pop && (burst_cnt == LW'(1));
      if (pop) data_q <= mem[rd_ptr];
    end
  end
endmodule

// File: tb/tb_sample_burst_framer.sv
// Randomized + directed bench for sample_burst_framer with a queue-based
// reference model and a scoreboard monitor sampling on the falling edge.
module tb_sample_burst_framer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int BL    = 4;
  localparam int GAPC  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sample_burst_framer_if #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) bus ();

  sample_burst_framer #(
    .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .GAP_CYCLES(GAPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             last;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples held in a queue. Rules: a burst of BL starts
  // once BL samples wait, or a flush releases whatever waits; words leave
  // one per cycle; after a burst nothing may start for GAPC+1 cycles.
  logic [WIDTH-1:0] mq[$];
  exp_t             exp_q[$];
  int               remain = 0;
  int               hold   = 0;
  bit               mdv    = 0;
  logic [WIDTH-1:0] mlast  = '0;

  always @(posedge clk or posedge rst) begin
    int   lvl;
    bit   acc;
    exp_t e;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      remain = 0;
      hold   = 0;
      mdv    = 0;
      mlast  = '0;
    end else begin
      lvl = mq.size();
      acc = bus.in_valid && (lvl != DEPTH);
      mdv = 0;
      if (remain > 0) begin
        e.d    = mq.pop_front();
        e.last = (remain == 1);
        exp_q.push_back(e);
        mlast  = e.d;
        mdv    = 1;
        remain--;
        if (remain == 0) hold = GAPC + 1;
      end else if (hold > 0) begin
        hold--;
      end else if (lvl >= BL) begin
        remain = BL;
      end else if (bus.flush && lvl > 0) begin
        remain = lvl;
      end
      if (acc) mq.push_back(bus.in_data);
    end
  end

  // Monitor: compare DUT outputs against the model each cycle and pop the
  // scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_dvalid", 32'(bus.dvalid), 32'd0);
      chk("rst_level", 32'(bus.fifo_level), 32'd0);
    end else begin
      chk("dvalid", 32'(bus.dvalid), 32'(mdv));
      chk("fifo_level", 32'(bus.fifo_level), 32'(mq.size()));
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
      chk("data_hold", 32'(bus.data_out), 32'(mlast));
      if (bus.dvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(bus.data_out), 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("data", 32'(bus.data_out), 32'(e.d));
          chk("burst_last", 32'(bus.burst_last), 32'(e.last));
        end
      end else begin
        chk("burst_last_idle", 32'(bus.burst_last), 32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Hold one sample until accepted (bounded).
  task automatic push1(input logic [WIDTH-1:0] d);
    int   n;
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    do begin
      acc = bus.in_ready;
      cyc();
      n++;
    end while (!acc && n < 200);
    bus.in_valid = 1'b0;
    chk("push_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic push_run(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) push1(base + WIDTH'(i));
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
  endtask

  task automatic wait_dvalid();
    int n;
    n = 0;
    while (!bus.dvalid && n < 100) begin
      cyc();
      n++;
    end
    chk("wait_dvalid_timeout", 32'(bus.dvalid), 32'd1);
  endtask

  // Flush repeatedly until everything buffered has been emitted and the gap
  // has elapsed.
  task automatic drain();
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    bus.in_valid = 1'b0;
    while (!done && n < 400) begin
      done = (mq.size() == 0) && (exp_q.size() == 0) && (remain == 0) && (hold == 0);
      bus.flush = !done;
      cyc();
      n++;
    end
    bus.flush = 1'b0;
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // One full burst.
    push_run(8'h10, 4);
    idle(12);

    // Two back-to-back bursts separated by the fixed gap.
    push_run(8'h20, 8);
    idle(20);

    // Overfill so in_ready drops, with a final 0xFF waiting for a slot.
    push_run(8'h40, 30);
    push1(8'hFF);
    drain();

    // Partial burst released by flush, then a flush with nothing queued.
    push_run(8'h30, 2);
    idle(10);
    flush_pulse();
    idle(8);
    flush_pulse();
    idle(5);

    // Flush during SEND is ignored; the fifth sample stays queued.
    push_run(8'h50, 5);
    wait_dvalid();
    flush_pulse();
    idle(15);
    flush_pulse();
    idle(8);

    // Reset in the middle of a burst discards everything buffered.
    push_run(8'h60, 7);
    wait_dvalid();
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    idle(10);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = WIDTH'($urandom);
      bus.flush    = ($urandom_range(0, 15) == 0);
      cyc();
    end
    bus.flush = 1'b0;
    drain();
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
